arp_parser: RTL

Parses the 28-byte ARP body of a received Ethernet frame, delivered as an N-bit-wide MSB-first stream by the receive path after the EtherType has been classified as ARP (0x0806). Validates the fixed header fields, checks the target protocol address against the local IP, and presents sender MAC, sender IP and opcode with a one-cycle valid pulse to the ARP responder. Sits between the EtherType classifier and the ARP reply generator.

---
 rtl/arp_pkg.sv | 36 +++
 rtl/arp_parser.sv | 110 +++++++++++
 2 files changed

// File: rtl/arp_pkg.sv
// Shared ARP constants, field byte offsets and parser state encoding.
package arp_pkg;

    localparam int unsigned ARP_BODY_BYTES = 28;
    localparam int unsigned ARP_BODY_BITS  = ARP_BODY_BYTES * 8;

    localparam logic [15:0] HTYPE_ETH    = 16'h0001;
    localparam logic [15:0] PTYPE_IPV4   = 16'h0800;
    localparam logic [7:0]  HLEN_ETH     = 8'd6;
    localparam logic [7:0]  PLEN_IPV4    = 8'd4;
    localparam logic [15:0] OPER_REQUEST = 16'd1;
    localparam logic [15:0] OPER_REPLY   = 16'd2;

    localparam int unsigned OFF_HTYPE = 0;
    localparam int unsigned OFF_PTYPE = 2;
    localparam int unsigned OFF_HLEN  = 4;
    localparam int unsigned OFF_PLEN  = 5;
    localparam int unsigned OFF_OPER  = 6;
    localparam int unsigned OFF_SHA   = 8;
    localparam int unsigned OFF_SPA   = 14;
    localparam int unsigned OFF_THA   = 18;
    localparam int unsigned OFF_TPA   = 24;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_DRAIN
    } arp_state_t;

    // MSB bit index of the byte at a given offset within the MSB-first body.
    function automatic int unsigned field_msb(input int unsigned off);
        return ARP_BODY_BITS - 1 - 8 * off;
    endfunction

endpackage

// File: rtl/arp_parser.sv
// Parses the 28-byte ARP body from an N-bit MSB-first stream, validates the
// fixed header and TPA, and reports sender MAC/IP and opcode with a one-cycle pulse.
module arp_parser
    import arp_pkg::*;
#(
    parameter int unsigned N     = 2,
    parameter logic [31:0] MY_IP = 32'hC0A8_0102
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  axiid,
    input  logic          axiiv,
    output logic          arp_valid,
    output logic          arp_drop,
    output logic          arp_is_request,
    output logic [47:0]   sender_mac,
    output logic [31:0]   sender_ip
);

    localparam int unsigned BEATS = ARP_BODY_BITS / N;
    localparam int unsigned CW    = $clog2(BEATS) + 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(BEATS - 1);

    arp_state_t                   state;
    logic [CW-1:0]                count;
    // The newest beat is never stored; it is appended combinationally below.
    logic [ARP_BODY_BITS-N-1:0]   body;
    logic [ARP_BODY_BITS-1:0]     body_next;

    logic [15:0] f_htype;
    logic [15:0] f_ptype;
    logic [7:0]  f_hlen;
    logic [7:0]  f_plen;
    logic [15:0] f_oper;
    logic [47:0] f_sha;
    logic [31:0] f_spa;
    logic [31:0] f_tpa;
    logic        frame_ok;

    always_comb begin
        body_next = {body, axiid};
        f_htype   = body_next[field_msb(OFF_HTYPE) -: 16];
        f_ptype   = body_next[field_msb(OFF_PTYPE) -: 16];
        f_hlen    = body_next[field_msb(OFF_HLEN)  -: 8];
        f_plen    = body_next[field_msb(OFF_PLEN)  -: 8];
        f_oper    = body_next[field_msb(OFF_OPER)  -: 16];
        f_sha     = body_next[field_msb(OFF_SHA)   -: 48];
        f_spa     = body_next[field_msb(OFF_SPA)   -: 32];
        f_tpa     = body_next[field_msb(OFF_TPA)   -: 32];
        frame_ok  = (f_htype == HTYPE_ETH) && (f_ptype == PTYPE_IPV4) &&
                    (f_hlen == HLEN_ETH) && (f_plen == PLEN_IPV4) &&
                    ((f_oper == OPER_REQUEST) || (f_oper == OPER_REPLY)) &&
                    (f_tpa == MY_IP);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ST_DRAIN;
            count          <= '0;
            body           <= '0;
            arp_valid      <= 1'b0;
            arp_drop       <= 1'b0;
            arp_is_request <= 1'b0;
            sender_mac     <= '0;
            sender_ip      <= '0;
        end else begin
            arp_valid <= 1'b0;
            arp_drop  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (axiiv) begin
                        body  <= body_next[ARP_BODY_BITS-N-1:0];
                        count <= CW'(1);
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (axiiv) begin
                        body  <= body_next[ARP_BODY_BITS-N-1:0];
                        count <= count + CW'(1);
                        if (count == LAST_COUNT) begin
                            // Verdict is registered on the last-beat edge so the pulse
                            // occupies the CHECK cycle, one cycle after that beat.
                            state <= ST_CHECK;
                            if (frame_ok) begin
                                arp_valid      <= 1'b1;
                                arp_is_request <= (f_oper == OPER_REQUEST);
                                sender_mac     <= f_sha;
                                sender_ip      <= f_spa;
                            end else begin
                                arp_drop <= 1'b1;
                            end
                        end
                    end else begin
                        arp_drop <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    state <= axiiv ? ST_DRAIN : ST_IDLE;
                end
                ST_DRAIN: begin
                    if (!axiiv) state <= ST_IDLE;
                end
                default: state <= ST_DRAIN;
            endcase
        end
    end

endmodule
